// File: rtl/addr_seq_engine.sv
// Address sequencing stage: pops FIFO words and expands each into 1..256
// consecutive vector addresses on a valid/ready port, with issue counters.
module addr_seq_engine #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run_program,
    input  logic                            active_program,
    input  logic                            abort_program,
    input  logic                            freeze_addr_fifo,
    input  logic                            send_consec_addr,
    input  logic [7:0]                      consec_count,
    input  logic [31:0]                     fifo_dout,
    input  logic                            fifo_empty,
    output logic                            fifo_rd_en,
    output logic [31:0]                     vctr_addr,
    output logic                            vctr_addr_valid,
    input  logic                            vctr_addr_ready,
    output logic [CNT_W-1:0]                addr_cycle_cnt,
    output logic [(1<<TAG_W)*CNT_W-1:0]     addr_mon_cnts_flat,
    output logic                            seq_idle
);

    localparam int ADDR_W   = 32 - TAG_W;
    localparam int NUM_TAGS = 1 << TAG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t             state;
    logic [TAG_W-1:0]   tag;
    logic [ADDR_W-1:0]  cur_addr;
    logic [7:0]         remaining;
    logic [CNT_W-1:0]   mon [NUM_TAGS];

    logic can_pop;
    logic handshake;
    logic last_beat;
    logic load;
    logic counter_clear;
    logic count_en;

    always_comb begin
        can_pop       = active_program & ~abort_program & ~freeze_addr_fifo & ~fifo_empty;
        handshake     = vctr_addr_valid & vctr_addr_ready;
        last_beat     = (remaining == 8'd0);
        load          = ~abort_program & can_pop &
                        ((state == IDLE) | ((state == ISSUE) & handshake & last_beat));
        // The strobe is combinational, so gate it with reset to keep it quiet
        // while the abort flush would otherwise be enabled.
        fifo_rd_en    = reset & (load | (abort_program & ~fifo_empty));
        counter_clear = run_program & ~active_program;
        count_en      = handshake & ~abort_program;
    end

    assign vctr_addr = {tag, cur_addr};
    assign seq_idle  = (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            tag             <= '0;
            cur_addr        <= '0;
            remaining       <= '0;
            vctr_addr_valid <= 1'b0;
        end else if (abort_program) begin
            state           <= IDLE;
            remaining       <= '0;
            vctr_addr_valid <= 1'b0;
        end else if (load) begin
            tag             <= fifo_dout[31 -: TAG_W];
            cur_addr        <= fifo_dout[ADDR_W-1:0];
            remaining       <= send_consec_addr ? consec_count : 8'd0;
            state           <= ISSUE;
            vctr_addr_valid <= 1'b1;
        end else if ((state == ISSUE) && handshake) begin
            if (!last_beat) begin
                // Address field wraps on its own; the tag is never disturbed.
                cur_addr  <= cur_addr + ADDR_W'(1);
                remaining <= remaining - 8'd1;
            end else begin
                state           <= IDLE;
                vctr_addr_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cycle_cnt <= '0;
            // NOTE: the monitor array is a bank of readable counters, not RAM,
            // so every entry must be reset to a defined value.
            for (int i = 0; i < NUM_TAGS; i++) begin
                mon[i] <= '0;
            end
        end else if (counter_clear) begin
            addr_cycle_cnt <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                mon[i] <= '0;
            end
        end else if (count_en) begin
            if (addr_cycle_cnt != CNT_MAX) begin
                addr_cycle_cnt <= addr_cycle_cnt + CNT_W'(1);
            end
            if (mon[tag] != CNT_MAX) begin
                mon[tag] <= mon[tag] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        addr_mon_cnts_flat = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            addr_mon_cnts_flat[i*CNT_W +: CNT_W] = mon[i];
        end
    end

endmodule

// File: tb/tb_addr_seq_engine.sv
// Scoreboard bench for addr_seq_engine: a queue-backed FIFO model feeds the
// DUT and every accepted address is compared against the expected-address queue.
module tb_addr_seq_engine;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               run_program = 1'b0;
    logic               active_program = 1'b0;
    logic               abort_program = 1'b0;
    logic               freeze_addr_fifo = 1'b0;
    logic               send_consec_addr = 1'b0;
    logic [7:0]         consec_count = 8'd0;
    logic [31:0]        fifo_dout;
    logic               fifo_empty;
    logic               fifo_rd_en;
    logic [31:0]        vctr_addr;
    logic               vctr_addr_valid;
    logic               vctr_addr_ready = 1'b0;
    logic [15:0]        addr_cycle_cnt;
    logic [16*16-1:0]   addr_mon_cnts_flat;
    logic               seq_idle;

    int                 checks = 0;
    int                 errors = 0;
    int                 pop_count = 0;
    int                 hs_count = 0;
    bit                 sb_en = 1'b1;
    logic [31:0]        fifo_q[$];
    logic [31:0]        exp_q[$];

    addr_seq_engine #(.TAG_W(4), .CNT_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .run_program        (run_program),
        .active_program     (active_program),
        .abort_program      (abort_program),
        .freeze_addr_fifo   (freeze_addr_fifo),
        .send_consec_addr   (send_consec_addr),
        .consec_count       (consec_count),
        .fifo_dout          (fifo_dout),
        .fifo_empty         (fifo_empty),
        .fifo_rd_en         (fifo_rd_en),
        .vctr_addr          (vctr_addr),
        .vctr_addr_valid    (vctr_addr_valid),
        .vctr_addr_ready    (vctr_addr_ready),
        .addr_cycle_cnt     (addr_cycle_cnt),
        .addr_mon_cnts_flat (addr_mon_cnts_flat),
        .seq_idle           (seq_idle)
    );

    always #5 clk = ~clk;

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 32'h0 : fifo_q[0];
    endtask

    task automatic fifo_push(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_refresh();
    endtask

    // FIFO model: the pop strobe is sampled before the edge settles, the head
    // advances 1 ns later.
    always @(posedge clk) begin
        logic rd;
        rd = fifo_rd_en;
        #1;
        if (rd) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_count++;
        end
        fifo_refresh();
    end

    // Scoreboard: every accepted address is compared with the queue head.
    always @(posedge clk) begin
        logic [31:0] exp_addr;
        if (reset && vctr_addr_valid && vctr_addr_ready) begin
            hs_count++;
            if (sb_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h, required no address", vctr_addr);
                end else begin
                    exp_addr = exp_q.pop_front();
                    if (vctr_addr !== exp_addr) begin
                        errors++;
                        $display("FAIL sb_addr: got %h, required %h", vctr_addr, exp_addr);
                    end
                end
            end
        end
    end

    function automatic logic [15:0] mon_of(input int t);
        return addr_mon_cnts_flat[t*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic clear_counters();
        active_program = 1'b0;
        run_program = 1'b1;
        tick();
        run_program = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int bound);
        int n;
        tick();
        n = 0;
        while (!(seq_idle && fifo_empty) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, bound);
        end
    endtask

    task automatic test_reset();
        fifo_push(32'h1234_5678);
        abort_program = 1'b1;
        #3;
        chk("reset_rd_en", 32'(fifo_rd_en), 32'h0);
        chk("reset_valid", 32'(vctr_addr_valid), 32'h0);
        chk("reset_addr", vctr_addr, 32'h0);
        chk("reset_cnt", 32'(addr_cycle_cnt), 32'h0);
        chk("reset_idle", 32'(seq_idle), 32'h1);
        chk("reset_mon_or", 32'(|addr_mon_cnts_flat), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        abort_program = 1'b0;
        chk("reset_flush_empty", 32'(fifo_empty), 32'h1);
    endtask

    task automatic test_single_word();
        int p0;
        clear_counters();
        send_consec_addr = 1'b0;
        vctr_addr_ready = 1'b1;
        exp_q.push_back(32'h3000_0100);
        fifo_push(32'h3000_0100);
        p0 = pop_count;
        active_program = 1'b1;
        tick();
        chk("single_latency_valid", 32'(vctr_addr_valid), 32'h1);
        run_until_idle("single", 20);
        active_program = 1'b0;
        chk("single_pops", 32'(pop_count - p0), 32'd1);
        chk("single_cnt", 32'(addr_cycle_cnt), 32'd1);
        chk("single_mon3", 32'(mon_of(3)), 32'd1);
        chk("single_idle", 32'(seq_idle), 32'h1);
        chk("single_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_burst_wrap();
        clear_counters();
        send_consec_addr = 1'b1;
        consec_count = 8'd3;
        vctr_addr_ready = 1'b1;
        exp_q.push_back(32'h5FFF_FFFE);
        exp_q.push_back(32'h5FFF_FFFF);
        exp_q.push_back(32'h5000_0000);
        exp_q.push_back(32'h5000_0001);
        fifo_push(32'h5FFF_FFFE);
        active_program = 1'b1;
        run_until_idle("burst", 20);
        active_program = 1'b0;
        chk("burst_mon5", 32'(mon_of(5)), 32'd4);
        chk("burst_cnt", 32'(addr_cycle_cnt), 32'd4);
        chk("burst_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_backpressure();
        int p0;
        clear_counters();
        send_consec_addr = 1'b1;
        consec_count = 8'd3;
        vctr_addr_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h7000_0010 + 32'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h7000_0200 + 32'(i));
        fifo_push(32'h7000_0010);
        fifo_push(32'h7000_0200);
        active_program = 1'b1;
        tick();
        tick();
        vctr_addr_ready = 1'b0;
        p0 = pop_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(vctr_addr_valid), 32'h1);
            chk("bp_addr", vctr_addr, 32'h7000_0011);
            chk("bp_cnt", 32'(addr_cycle_cnt), 32'd1);
            chk("bp_no_pop", 32'(pop_count - p0), 32'd0);
        end
        vctr_addr_ready = 1'b1;
        run_until_idle("bp", 30);
        active_program = 1'b0;
        chk("bp_cnt_final", 32'(addr_cycle_cnt), 32'd8);
        chk("bp_mon7", 32'(mon_of(7)), 32'd8);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_back_to_back();
        clear_counters();
        send_consec_addr = 1'b0;
        vctr_addr_ready = 1'b1;
        exp_q.push_back(32'h1000_0001);
        exp_q.push_back(32'h2000_0002);
        exp_q.push_back(32'h1000_0003);
        fifo_push(32'h1000_0001);
        fifo_push(32'h2000_0002);
        fifo_push(32'h1000_0003);
        active_program = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("b2b_valid", 32'(vctr_addr_valid), 32'h1);
            tick();
        end
        chk("b2b_valid_end", 32'(vctr_addr_valid), 32'h0);
        active_program = 1'b0;
        chk("b2b_cnt", 32'(addr_cycle_cnt), 32'd3);
        chk("b2b_mon1", 32'(mon_of(1)), 32'd2);
        chk("b2b_mon2", 32'(mon_of(2)), 32'd1);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_abort();
        int base;
        int n;
        clear_counters();
        send_consec_addr = 1'b1;
        consec_count = 8'd10;
        vctr_addr_ready = 1'b1;
        exp_q.push_back(32'h4000_0100);
        exp_q.push_back(32'h4000_0101);
        fifo_push(32'h4000_0100);
        for (int i = 0; i < 4; i++) fifo_push(32'h4000_1000 + 32'(i));
        base = hs_count;
        active_program = 1'b1;
        n = 0;
        while (hs_count < base + 2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (hs_count < base + 2) begin
            errors++;
            $display("FAIL abort_wait: got %0d handshakes, required 2", hs_count - base);
        end
        abort_program = 1'b1;
        vctr_addr_ready = 1'b0;
        tick();
        chk("abort_valid", 32'(vctr_addr_valid), 32'h0);
        chk("abort_idle", 32'(seq_idle), 32'h1);
        for (int i = 0; i < 3; i++) tick();
        abort_program = 1'b0;
        active_program = 1'b0;
        chk("abort_drained", 32'(fifo_empty), 32'h1);
        chk("abort_cnt", 32'(addr_cycle_cnt), 32'd2);
        chk("abort_mon4", 32'(mon_of(4)), 32'd2);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_freeze();
        int p0;
        clear_counters();
        send_consec_addr = 1'b0;
        vctr_addr_ready = 1'b1;
        exp_q.push_back(32'h6000_0040);
        exp_q.push_back(32'h6000_0041);
        fifo_push(32'h6000_0040);
        fifo_push(32'h6000_0041);
        freeze_addr_fifo = 1'b1;
        p0 = pop_count;
        active_program = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("freeze_no_pop", 32'(pop_count - p0), 32'd0);
        chk("freeze_valid", 32'(vctr_addr_valid), 32'h0);
        freeze_addr_fifo = 1'b0;
        run_until_idle("freeze", 20);
        active_program = 1'b0;
        chk("freeze_cnt", 32'(addr_cycle_cnt), 32'd2);
        chk("freeze_mon6", 32'(mon_of(6)), 32'd2);
    endtask

    task automatic test_saturation();
        clear_counters();
        sb_en = 1'b0;
        send_consec_addr = 1'b1;
        consec_count = 8'd255;
        vctr_addr_ready = 1'b1;
        // 256 words x 256 addresses = 65536 handshakes, one past the limit.
        for (int i = 0; i < 256; i++) fifo_push(32'h9000_0000 + 32'(i * 256));
        active_program = 1'b1;
        run_until_idle("sat", 70000);
        active_program = 1'b0;
        chk("sat_cnt", 32'(addr_cycle_cnt), 32'h0000_FFFF);
        chk("sat_mon9", 32'(mon_of(9)), 32'h0000_FFFF);
        clear_counters();
        chk("clear_cnt", 32'(addr_cycle_cnt), 32'h0);
        chk("clear_mon9", 32'(mon_of(9)), 32'h0);
        sb_en = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        clear_counters();
        sb_en = 1'b0;
        send_consec_addr = 1'b1;
        consec_count = 8'd5;
        vctr_addr_ready = 1'b1;
        fifo_push(32'h2000_0000);
        fifo_push(32'h2000_0100);
        active_program = 1'b1;
        tick();
        tick();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(vctr_addr_valid), 32'h0);
        chk("rst_mid_addr", vctr_addr, 32'h0);
        chk("rst_mid_cnt", 32'(addr_cycle_cnt), 32'h0);
        chk("rst_mid_idle", 32'(seq_idle), 32'h1);
        chk("rst_mid_rd_en", 32'(fifo_rd_en), 32'h0);
        active_program = 1'b0;
        fifo_q.delete();
        fifo_refresh();
        tick();
        reset = 1'b1;
        sb_en = 1'b1;
    endtask

    initial begin
        fifo_refresh();
        test_reset();
        test_single_word();
        test_burst_wrap();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_freeze();
        test_saturation();
        test_reset_mid_burst();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_seq_engine.md
# addr_seq_engine

Address sequencing stage directly downstream of the driver control register block's address FIFO. Pops 32-bit address words from a first-word-fall-through FIFO while a program is active and expands each word into 1 to 256 consecutive vector addresses. Presents the addresses to the vector fetch stage over a valid/ready handshake. Produces the issued-address count and per-tag monitor counters that the register block reads back.

## Interface

Parameters:
- TAG_W, 4, tag field width; the tag is the top TAG_W bits of each FIFO word and selects one of 2^TAG_W monitor counters.
- CNT_W, 16, width of every counter.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- run_program  in  1  program start level.
- active_program  in  1  program in progress.
- abort_program  in  1  abort level.
- freeze_addr_fifo  in  1  blocks FIFO pops.
- send_consec_addr  in  1  enables burst expansion.
- consec_count  in  8  additional consecutive addresses per word.
- fifo_dout  in  32  FIFO head word, valid when fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe, combinational.
- vctr_addr  out  32  {tag, 28-bit address}, registered.
- vctr_addr_valid  out  1  address valid, registered.
- vctr_addr_ready  in  1  downstream accept.
- addr_cycle_cnt  out  CNT_W  addresses issued, saturating.
- addr_mon_cnts_flat  out  16*CNT_W  per-tag issued counts; tag n occupies bits [n*CNT_W +: CNT_W].
- seq_idle  out  1  high in IDLE.

## Operation

- States: IDLE, ISSUE.
- can_pop = active_program & ~abort_program & ~freeze_addr_fifo & ~fifo_empty.
- fifo_rd_en = (IDLE & can_pop) | (ISSUE & handshake & remaining==0 & can_pop) | (abort_program & ~fifo_empty).
- Load on pop (non-abort):
  - tag <= fifo_dout[31:28]
  - cur_addr <= fifo_dout[27:0]
  - remaining <= send_consec_addr ? consec_count : 0, sampled at the pop
  - state <= ISSUE
- ISSUE:
  - vctr_addr_valid=1, vctr_addr={tag,cur_addr}.
  - vctr_addr and vctr_addr_valid stay stable until handshake (valid&ready) or abort.
- On handshake:
  - addr_cycle_cnt and mon[tag] increment, each saturating at 2^CNT_W-1.
  - If remaining!=0: cur_addr <= cur_addr+1, wrapping modulo 2^28 with the tag unchanged; remaining <= remaining-1.
  - Else if can_pop: load the next word, back-to-back.
  - Else: go to IDLE.
- freeze_addr_fifo only blocks pops. An in-progress burst still completes.
- Dropping active_program mid-burst: the burst completes and no further pops occur.
- Abort takes priority over everything:
  - Next state is IDLE; remaining is cleared; vctr_addr_valid drops on the next edge even without ready.
  - The FIFO is flushed one word per cycle while abort_program=1.
  - Counters are not cleared.
- Counter clear: run_program & ~active_program clears all counters. If a handshake occurs in the same cycle, the clear wins.

## Timing

- Reset (asynchronous, low): state=IDLE, vctr_addr=0, vctr_addr_valid=0, all counters=0, remaining=0. fifo_rd_en is 0 while reset is asserted. seq_idle=1.
- Latency: pop in cycle N gives vctr_addr_valid=1 in cycle N+1.
- Throughput: one address per cycle while ready=1, including across word boundaries.
- A word with consec_count=K and send_consec_addr=1 yields K+1 addresses.
- Counter updates are visible the cycle after the handshake.
- Abort asserted in cycle N: valid=0 and state=IDLE from cycle N+1.
- Reset asserted mid-burst: all outputs return to reset values immediately. The rest of the burst is discarded.

## Test plan

- Single word, no burst:
  - Stimulus: FIFO holds 0x3000_0100, active=1, send_consec_addr=0, ready=1.
  - Response: one vctr_addr=0x3000_0100; fifo_rd_en pulses once; addr_cycle_cnt=1; mon[3]=1; back to IDLE.
- Burst with wrap:
  - Stimulus: word 0x5FFF_FFFE, send_consec_addr=1, consec_count=3.
  - Response: addresses 0x5FFF_FFFE, 0x5FFF_FFFF, 0x5000_0000, 0x5000_0001; mon[5]=4.
- Backpressure:
  - Stimulus: ready low for 5 cycles mid-burst.
  - Response: valid and address held constant; no counter change; no pop.
- Back-to-back:
  - Stimulus: 3 words with tags 1, 2, 1, ready=1.
  - Response: valid high 3 consecutive cycles; addr_cycle_cnt=3; mon[1]=2; mon[2]=1.
- Abort mid-burst:
  - Stimulus: consec_count=10; abort after 2 handshakes with 4 words queued; abort held 4 cycles.
  - Response: valid=0 next cycle; FIFO drained to empty; addr_cycle_cnt=2.
- Freeze and saturation:
  - Stimulus: freeze=1 with words queued; separately, preload 0xFFFF handshakes.
  - Response: no pop while frozen; addr_cycle_cnt holds at 0xFFFF; run_program with active_program=0 clears it to 0.
